mlp_dispatch_sched: RTL

Packet scheduler between a single AXI-stream source and the four `mlp_1` dispatcher input FIFOs, plus the read-side drain controller for the `mlp_1` collector output FIFO. It distributes whole packets, delimited by `tlast`, round-robin across dispatchers 0..3. It applies the dispatcher `rdy` backpressure to the source. It converts the collector's ren/rdata FIFO port (1-cycle read latency) into an AXI-stream master.

---
 rtl/mlp_noc_pkg.sv | 13 +
 rtl/mlp_ofifo_drain.sv | 56 +++++
 rtl/mlp_dispatch_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mlp_noc_pkg.sv
// Shared types and defaults for the mlp_1 NoC glue logic (dispatch scheduler, drains).
package mlp_noc_pkg;

    localparam int DATA_WIDTH_DEFAULT = 64;
    localparam int NUM_DISP_DEFAULT   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        STOP
    } sched_state_t;

endpackage

// File: rtl/mlp_ofifo_drain.sv
// Collector ofifo drain: turns a 1-cycle-latency ren/rdata FIFO port into an
// AXI-stream master through a 2-entry registered output buffer.
module mlp_ofifo_drain #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] col_rdata,
    output logic                  col_ren,
    input  logic                  col_rdy,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    logic [DATA_WIDTH-1:0] entry [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  in_flight;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;

    // A read is only issued when the word it returns is guaranteed a free slot.
    assign col_ren       = reset_n & col_rdy & ((count + {1'b0, in_flight}) < 2'd2);
    assign push          = in_flight;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = entry[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_flight <= 1'b0;
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            entry[0]  <= '0;
            entry[1]  <= '0;
        end else begin
            in_flight <= col_ren;
            if (push) begin
                entry[wr_ptr] <= col_rdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mlp_dispatch_sched.sv
// Round-robin packet scheduler feeding the mlp_1 dispatchers, plus collector drain.
// Optional per-dispatcher/packet statistics under `MLP_DISPATCH_SCHED_STATS_EN.
module mlp_dispatch_sched
    import mlp_noc_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int NUM_DISP      = NUM_DISP_DEFAULT,
    parameter int MAX_PKT_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [NUM_DISP*DATA_WIDTH-1:0] disp_wdata,
    output logic [NUM_DISP-1:0]            disp_wen,
    input  logic [NUM_DISP-1:0]            disp_rdy,
    input  logic [DATA_WIDTH-1:0]          col_rdata,
    output logic                           col_ren,
    input  logic                           col_rdy,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
`ifdef MLP_DISPATCH_SCHED_STATS_EN
    output logic [NUM_DISP*32-1:0]         disp_word_cnt,
    output logic [31:0]                    pkt_cnt,
`endif
    output logic [$clog2(NUM_DISP)-1:0]    cur_disp,
    output logic                           err_oversize
);

    localparam int DISP_W = $clog2(NUM_DISP);
    localparam int CNT_W  = $clog2(MAX_PKT_WORDS + 1);

    sched_state_t     state;
    sched_state_t     state_next;
    logic [CNT_W-1:0] word_cnt;
    logic             sending;
    logic             accept;
    logic             at_limit;
    logic             pkt_end;

    assign sending       = reset_n & (state == SEND);
    assign s_axis_tready = sending & disp_rdy[cur_disp];
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign at_limit      = (word_cnt == CNT_W'(MAX_PKT_WORDS - 1));
    assign pkt_end       = accept & (s_axis_tlast | at_limit);
    assign disp_wdata    = {NUM_DISP{s_axis_tdata}};

    always_comb begin
        disp_wen = '0;
        if (accept) begin
            disp_wen[cur_disp] = 1'b1;
        end
    end

    // Packets are never truncated; with enable low and no packet open, wind down.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = SEND;
            end
            SEND: begin
                if (pkt_end) begin
                    state_next = enable ? SEND : STOP;
                end else if (!enable && (word_cnt == '0) && !accept) begin
                    state_next = STOP;
                end
            end
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            word_cnt     <= '0;
            cur_disp     <= '0;
            err_oversize <= 1'b0;
        end else begin
            state <= state_next;
            if (pkt_end) begin
                word_cnt <= '0;
                cur_disp <= cur_disp + DISP_W'(1);
            end else if (accept) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (accept && at_limit && !s_axis_tlast) begin
                err_oversize <= 1'b1;
            end
        end
    end

`ifdef MLP_DISPATCH_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            disp_word_cnt <= '0;
            pkt_cnt       <= '0;
        end else begin
            if (accept) begin
                disp_word_cnt[cur_disp*32 +: 32] <= disp_word_cnt[cur_disp*32 +: 32] + 32'd1;
            end
            if (pkt_end) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end
`endif

    mlp_ofifo_drain #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_drain (
        .clk          (clk),
        .reset_n      (reset_n),
        .col_rdata    (col_rdata),
        .col_ren      (col_ren),
        .col_rdy      (col_rdy),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

endmodule
